// File: rtl/clock_gen_multi.sv
// Multi-channel programmable clock generator: per-channel period/high-time
// counters with shadowed settings that only take effect on period boundaries.
module clock_gen_multi #(
  parameter  int N_CH       = 2,
  parameter  int W          = 16,
  parameter  int DEF_PERIOD = 4,
  parameter  int DEF_HIGH   = 2,
  localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [N_CH-1:0] on_in,
  input  logic            sync_in,
  input  logic            cfg_wr_in,
  input  logic [CW-1:0]   cfg_ch_in,
  input  logic [W-1:0]    cfg_period_in,
  input  logic [W-1:0]    cfg_high_in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] tick_out,
  output logic [N_CH-1:0] busy_out
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e         r_state;
    logic [W-1:0]   r_cnt, r_p, r_h, r_ps, r_hs;
    logic           r_out, r_tick, r_busy;
    logic           w_wr, w_wrap, w_done;
    logic [W-1:0]   w_ps, w_hs, w_last, w_cnt_inc;

    // A write landing on the same edge as a load is forwarded straight to
    // the active settings, so it is never lost or delayed by a period.
    assign w_wr      = cfg_wr_in && (cfg_ch_in == CW'(g));
    assign w_ps      = w_wr ? cfg_period_in : r_ps;
    assign w_hs      = w_wr ? cfg_high_in   : r_hs;
    assign w_last    = (r_p < W'(2)) ? W'(1) : r_p - W'(1);
    assign w_wrap    = (r_cnt == w_last);
    assign w_cnt_inc = r_cnt + W'(1);
    // Leave for IDLE once the running period is complete and on is low;
    // a sync on a RUN channel restarts the period instead.
    assign w_done    = !on_in[g] && ((r_state == STOP) || !sync_in);

    always_ff @(posedge clk_in) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order in this block.
      if (!rst_n_in) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_p     <= W'(DEF_PERIOD);
        r_h     <= W'(DEF_HIGH);
        r_ps    <= W'(DEF_PERIOD);
        r_hs    <= W'(DEF_HIGH);
        r_out   <= 1'b0;
        r_tick  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_ps   <= w_ps;
        r_hs   <= w_hs;
        r_tick <= 1'b0;
        case (r_state)
          IDLE: begin
            r_p   <= w_ps;
            r_h   <= w_hs;
            r_cnt <= '0;
            r_out <= 1'b0;
            if (on_in[g]) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_tick  <= 1'b1;
              r_out   <= (w_hs != '0);
            end
          end
          default: begin
            if (sync_in || w_wrap) begin
              r_p   <= w_ps;
              r_h   <= w_hs;
              r_cnt <= '0;
              if (w_done) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_out   <= 1'b0;
              end else begin
                r_state <= on_in[g] ? RUN : STOP;
                r_tick  <= 1'b1;
                r_out   <= (w_hs != '0);
              end
            end else begin
              r_cnt   <= w_cnt_inc;
              r_out   <= (w_cnt_inc < r_h);
              r_state <= on_in[g] ? RUN : STOP;
            end
          end
        endcase
      end
    end

    assign out[g]      = r_out;
    assign tick_out[g] = r_tick;
    assign busy_out[g] = r_busy;
  end

endmodule

// File: tb/tb_clock_gen_multi.sv
// Scoreboard bench for clock_gen_multi: a cycle model pushes expected outputs
// per driven cycle; they are popped and compared one edge later.
module tb_clock_gen_multi;
  localparam int N  = 3;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [N-1:0]  on_in;
  logic          sync_in;
  logic          cfg_wr_in;
  logic [CW-1:0] cfg_ch_in;
  logic [W-1:0]  cfg_period_in;
  logic [W-1:0]  cfg_high_in;
  logic [N-1:0]  out, tick_out, busy_out;

  clock_gen_multi #(.N_CH(N), .W(W), .DEF_PERIOD(4), .DEF_HIGH(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .on_in(on_in), .sync_in(sync_in),
    .cfg_wr_in(cfg_wr_in), .cfg_ch_in(cfg_ch_in), .cfg_period_in(cfg_period_in),
    .cfg_high_in(cfg_high_in), .out(out), .tick_out(tick_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [N-1:0] o, t, b;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 = IDLE, 1 = RUN, 2 = STOP
  int m_state[N], m_cnt[N], m_p[N], m_h[N], m_ps[N], m_hs[N];
  bit m_tick[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit   wr;
    int   nps, nhs, pe;
    for (int c = 0; c < N; c++) begin
      wr  = cfg_wr_in && (int'(cfg_ch_in) == c);
      nps = wr ? int'(cfg_period_in) : m_ps[c];
      nhs = wr ? int'(cfg_high_in)   : m_hs[c];
      pe  = (m_p[c] < 2) ? 2 : m_p[c];
      m_tick[c] = 1'b0;
      if (!rst_n_in) begin
        m_state[c] = 0; m_cnt[c] = 0;
        m_p[c] = 4; m_ps[c] = 4; m_h[c] = 2; m_hs[c] = 2;
      end else begin
        if (m_state[c] == 0) begin
          m_p[c] = nps; m_h[c] = nhs; m_cnt[c] = 0;
          if (on_in[c]) begin m_state[c] = 1; m_tick[c] = 1'b1; end
        end else if (sync_in || m_cnt[c] == pe - 1) begin
          m_p[c] = nps; m_h[c] = nhs; m_cnt[c] = 0;
          if (on_in[c]) begin
            m_state[c] = 1; m_tick[c] = 1'b1;
          end else if (m_state[c] == 1 && sync_in) begin
            m_state[c] = 2; m_tick[c] = 1'b1;
          end else begin
            m_state[c] = 0;
          end
        end else begin
          m_cnt[c]++;
          m_state[c] = on_in[c] ? 1 : 2;
        end
        m_ps[c] = nps; m_hs[c] = nhs;
      end
      e.o[c] = (m_state[c] != 0) && (m_cnt[c] < m_h[c]);
      e.t[c] = m_tick[c];
      e.b[c] = (m_state[c] != 0);
    end
    exp_q.push_back(e);
  endtask

  // Drive-then-sample: inputs set before this call are consumed at the next edge.
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check("out", 32'(out), 32'(e.o));
    check("tick", 32'(tick_out), 32'(e.t));
    check("busy", 32'(busy_out), 32'(e.b));
    cfg_wr_in = 1'b0;
    sync_in   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_cnt(input int ch, input int val);
    int k;
    k = 0;
    while (m_cnt[ch] != val && k < 64) begin cycle(); k++; end
    if (k >= 64) check("wait_cnt_timeout", 32'd1, 32'd0);
  endtask

  task automatic write_cfg(input int ch, input int p, input int h);
    cfg_wr_in     = 1'b1;
    cfg_ch_in     = CW'(ch);
    cfg_period_in = W'(p);
    cfg_high_in   = W'(h);
  endtask

  bit pat[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_n_in = 1'b0; on_in = '0; sync_in = 1'b0; cfg_wr_in = 1'b0;
    cfg_ch_in = '0; cfg_period_in = '0; cfg_high_in = '0;
    #2;
    run(2);
    check("reset_out", 32'(out), 32'd0);
    check("reset_busy", 32'(busy_out), 32'd0);
    rst_n_in = 1'b1;
    run(2);

    // Default 1100 pattern with one-cycle latency from on_in
    on_in = 3'b001;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("pat_default", 32'(out[0]), 32'(pat[i]));
    end

    // Mid-period write waits for the wrap; wrap-edge write applies at once
    wait_cnt(0, 1);
    write_cfg(0, 10, 3);
    run(24);
    wait_cnt(0, 9);
    write_cfg(0, 6, 1);
    run(14);

    // Stop at cnt=1 finishes the period, then a STOP reassert without a gap
    write_cfg(0, 4, 2);
    wait_cnt(0, 0);
    wait_cnt(0, 1);
    on_in[0] = 1'b0;
    run(6);
    check("stop_idle_busy", 32'(busy_out[0]), 32'd0);
    on_in[0] = 1'b1;
    run(3);
    wait_cnt(0, 1);
    on_in[0] = 1'b0;
    cycle();
    on_in[0] = 1'b1;
    run(8);

    // Sync aligns channels with different periods
    write_cfg(1, 6, 3);
    cycle();
    on_in[1] = 1'b1;
    run(5);
    sync_in = 1'b1;
    cycle();
    check("sync_tick", 32'(tick_out[1:0]), 32'd3);
    check("sync_out", 32'(out[1:0]), 32'd3);
    run(8);

    // Boundaries on channel 2
    write_cfg(2, 0, 1);
    cycle();
    on_in[2] = 1'b1;
    run(6);
    write_cfg(2, 1, 0);
    run(8);
    write_cfg(2, 5, 5);
    run(12);
    write_cfg(3, 7, 7);
    run(12);
    // STOP channel taking a sync with on low drops to IDLE
    on_in[2] = 1'b0;
    cycle();
    sync_in = 1'b1;
    cycle();
    check("sync_stop_idle", 32'(busy_out[2]), 32'd0);

    // Reset mid-period with a pending shadow write
    wait_cnt(0, 1);
    write_cfg(0, 9, 5);
    cycle();
    rst_n_in = 1'b0;
    cycle();
    check("rst_mid_out", 32'({out, tick_out, busy_out}), 32'd0);
    rst_n_in = 1'b1;
    on_in = 3'b001;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("pat_after_rst", 32'(out[0]), 32'(pat[i]));
    end

    // Randomised mix of enables, syncs and writes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) on_in = N'($urandom);
      sync_in = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 5) == 0)
        write_cfg($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 10));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_gen_multi.md
CLOCK_GEN_MULTI -- requirements
Module: clock_gen_multi

Interface
REQ-001 Parameter N_CH, default 2, number of independent clock channels (1..16).
REQ-002 Parameter W, default 16, width of period and high-time counters.
REQ-003 Parameter DEF_PERIOD, default 4, reset value of every channel's period setting (cycles).
REQ-004 Parameter DEF_HIGH, default 2, reset value of every channel's high-time setting (cycles).
REQ-005 Port clk_in, input, 1, sole clock; all logic on rising edge.
REQ-006 Port rst_n_in, input, 1, reset; synchronous, active-low.
REQ-007 Port on_in, input, N_CH, per-channel run enable.
REQ-008 Port sync_in, input, 1, phase-align all running channels.
REQ-009 Port cfg_wr_in, input, 1, one-cycle configuration write strobe.
REQ-010 Port cfg_ch_in, input, max(1,$clog2(N_CH)), channel selected by the write.
REQ-011 Port cfg_period_in, input, W, new period in cycles.
REQ-012 Port cfg_high_in, input, W, new high time in cycles.
REQ-013 Port out, output, N_CH, registered generated clocks.
REQ-014 Port tick_out, output, N_CH, registered one-cycle pulse at each period start.
REQ-015 Port busy_out, output, N_CH, high while a channel is in RUN or STOP.

Function
REQ-016 Each channel SHALL hold shadow (P_s, H_s) and active (P, H) settings plus a W-bit counter cnt.
REQ-017 A cfg_wr_in pulse SHALL write cfg_period_in/cfg_high_in into the selected channel's shadow; cfg_ch_in >= N_CH SHALL be ignored.
REQ-018 Effective period Pe = max(P,2); cnt SHALL count 0..Pe-1 and wrap to 0.
REQ-019 Channel state machine SHALL have states IDLE, RUN, STOP.
REQ-020 IDLE: cnt=0, out=0, tick=0; shadow copied to active every cycle.
REQ-021 IDLE with on_in=1 -> RUN; after that edge cnt=0, out=(H>0), tick=1 (one-cycle latency from sampled on_in).
REQ-022 RUN/STOP: out=1 when cnt < H else 0; H=0 gives constant 0, H>=Pe gives constant 1.
REQ-023 At wrap (cnt=Pe-1) shadow SHALL be copied to active, so period/duty change only on period boundaries (glitch-free).
REQ-024 A write coinciding with the wrap edge SHALL be loaded at that wrap (write-through to active).
REQ-025 RUN with on_in=0 -> STOP; the current period completes unmodified.
REQ-026 STOP at wrap with on_in=0 -> IDLE, out=0; STOP with on_in=1 -> RUN with no interruption of out.
REQ-027 tick_out SHALL pulse for exactly one cycle whenever cnt becomes 0 in RUN (entry, wrap or sync).
REQ-028 sync_in=1 SHALL force cnt=0, tick=1 and shadow->active load in every channel in RUN or STOP, with priority over wrap; IDLE channels unaffected.
REQ-029 STOP channel receiving sync_in with on_in=0 SHALL go to IDLE.
REQ-030 Channels SHALL be fully independent apart from shared sync_in and config bus.

Reset
REQ-031 rst_n_in=0 sampled at an edge SHALL force all channels to IDLE, cnt=0, out=0, tick_out=0, busy_out=0, P=P_s=DEF_PERIOD, H=H_s=DEF_HIGH, overriding any in-progress period, write or sync.
REQ-032 First on_in sampled after rst_n_in returns high SHALL behave per REQ-021.

Verification
REQ-033 Defaults, on_in[0]=1 after reset -> out[0] pattern 1100 repeating, tick_out[0] every 4 cycles, first high one cycle after on_in sampled.
REQ-034 Write ch0 P=10,H=3 mid-period -> old 4-cycle period completes, then 3-high/7-low; write on wrap edge applies immediately.
REQ-035 Drop on_in[0] at cnt=1 -> out finishes period (cnt 1..3), then IDLE, busy_out=0; reassert during STOP -> no gap in pattern.
REQ-036 Ch0 P=4, ch1 P=6 running, pulse sync_in -> both cnt=0, both tick_out=1 same cycle, outputs rise together.
REQ-037 Boundaries: P=0/1 -> 2-cycle period; H=0 -> out stays 0 with ticks; H=P -> out constant 1; cfg_ch_in=N_CH -> no change.
REQ-038 Assert rst_n_in=0 mid-period with pending shadow write -> next cycle all outputs 0, settings DEF_PERIOD/DEF_HIGH.
